aes_shift_rows_collector: RTL and testbench
===========================================

Name: aes_shift_rows_collector

Overview:
Sits directly downstream of the four-S-box ByteSub row. Each cycle the ByteSub row produces one substituted 32-bit column; this block gathers four of them into a 128-bit state. It applies ShiftRows to the gathered state and presents the result to the MixColumns / AddRoundKey stage over a valid/ready handshake. The block also returns backpressure (col_ready) to the sequencer that drives the ByteSub row's enable and address.

Parameters:
BYTE_W, 8, byte width. Only 8 is legal; any other value is an elaboration error.
NB, 4, columns per state. Only 4 (AES-128 block) is legal; any other value is an elaboration error.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; discards any partial state
col_valid  in  1  col_data holds a substituted column
col_ready  out  1  block accepts a column this cycle
col_data  in  32  one column: [7:0]=row0, [15:8]=row1, [23:16]=row2, [31:24]=row3
out_valid  out  1  out_state holds a shifted state
out_ready  in  1  downstream consumes out_state
out_state  out  128  shifted state: column c at [32c+31:32c], row r of that column at bits [8r+7:8r] within it

Behaviour:
- Column transfer: occurs when col_valid && col_ready. Output transfer: occurs when out_valid && out_ready.
- Column counter col_cnt (2 bits, 0..3): counts accepted columns of the current state.
  - The accepted column is written to assembly buffer slot col_cnt.
  - col_cnt increments on each column transfer and wraps 3->0.
- Fourth column (col_cnt==3 and a column transfer):
  - The permutation is applied to slots 0..2 together with the incoming col_data, bypassing slot 3 storage.
  - The result loads into the out_state register and out_valid is set on the next edge.
  - Latency: out_valid rises exactly 1 cycle after the 4th column transfer.
- col_ready = (col_cnt != 3) || !out_valid || out_ready. This is a combinational path from out_ready.
  - Sustained throughput is 1 column/cycle when downstream is always ready.
- out_valid is cleared on an output transfer unless a new state loads on the same edge; in that case it stays 1 and out_state updates.
- ShiftRows: out[r][c] = s[r][(c+r) mod 4]. Row 0 is unshifted; rows 1/2/3 rotate left by 1/2/3.
- While out_valid && !out_ready, out_state and out_valid hold stable. Columns 0..2 of the next state may still be accepted meanwhile.
- clr:
  - Forces col_cnt=0 and out_valid=0 on the next edge; assembly buffer contents become don't-care.
  - clr has priority over a simultaneous column transfer or output transfer; those are discarded.
  - col_ready is driven 0 while clr=1.
- Reset (async, any time including mid-state): col_cnt=0, out_valid=0, out_state=0, assembly buffer=0, col_ready=1 after release.
- col_data is ignored when !col_valid.

Optional Feature:
AES_SR_INV_EN:
- When defined:
  - Adds input port inv (1 bit), sampled on the column-0 transfer and held for that state.
  - inv=1 selects InvShiftRows: out[r][c] = s[r][(c-r) mod 4]. inv=0 is forward ShiftRows.
  - A change of inv mid-state has no effect until the next column 0.
  - Reset and clr clear the latched inv to 0.
- When undefined: no inv port; forward ShiftRows only.

Decomposition:
- Package aes_pkg holds:
  - constants AES_NB=4 and AES_BYTE_W=8;
  - typedef aes_col_t (32-bit) and typedef aes_state_t (4x4 bytes);
  - pure functions shift_rows() and inv_shift_rows().
- One sub-module, aes_shift_rows_perm: the combinational permutation with a dir input. It is shared with the later decrypt datapath.

Test Plan:
- FIPS-197 App. B round 1: feed columns 32'hae1127d4, 32'hf198bfe0, 32'he55db4b8, 32'h3052411e back-to-back with out_ready=1.
  - Required: out_valid 1 cycle after the 4th column; out_state columns {0:32'h305dbfd4, 1:32'hae52b4e0, 2:32'hf11141b8, 3:32'he598271e}.
- Backpressure: hold out_ready=0 after the first state, then stream 4 more columns.
  - Required: columns 0..2 accepted; col_ready=0 at col_cnt==3; out_state stable.
  - Raising out_ready: 2nd state loads on the same edge the 1st drains; out_valid stays 1.
- Streaming: 3 states back-to-back with out_ready=1.
  - Required: col_ready never drops; one out_valid pulse every 4 cycles; each state correct.
- clr after 2 columns, then feed the 4-column App. B vector.
  - Required: output equals the App. B result (no stale columns); clr with out_valid=1 drops out_valid next edge.
- Reset asserted asynchronously mid-state (col_cnt=2, out_valid=1).
  - Required: out_valid=0 and out_state=0 immediately; the next 4 columns form a fresh correct state.
- (AES_SR_INV_EN) inv=1 with the shifted App. B columns as input.
  - Required: out_state equals the original SubBytes columns (32'hae1127d4 ...).

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES column/state types and ShiftRows permutation functions
// State layout is [column][row][bit], so column c occupies bits [32c+31:32c].
package aes_pkg;

  localparam int AES_NB     = 4;
  localparam int AES_BYTE_W = 8;

  typedef logic [AES_NB*AES_BYTE_W-1:0] aes_col_t;
  typedef logic [AES_NB-1:0][AES_NB-1:0][AES_BYTE_W-1:0] aes_state_t;

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < AES_NB; r++) begin
        o[c][r] = s[2'(c + r)][r];
      end
    end
    return o;
  endfunction

  // The 2-bit cast wraps a negative difference, giving (c - r) mod 4.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < AES_NB; r++) begin
        o[c][r] = s[2'(c - r)][r];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_shift_rows_collector_if.sv
// rtl/aes_shift_rows_collector_if.sv - column input and shifted-state output handshakes
// The collector uses the slave modport; the column source / state sink uses master.
interface aes_shift_rows_collector_if;
  import aes_pkg::*;

  logic         col_valid;
  logic         col_ready;
  aes_col_t     col_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output col_valid, col_data, out_ready,
    input  col_ready, out_valid, out_state
  );

  modport slave (
    input  col_valid, col_data, out_ready,
    output col_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_shift_rows_perm.sv
// rtl/aes_shift_rows_perm.sv - combinational ShiftRows (dir_i=0) / InvShiftRows (dir_i=1)
// Kept standalone so the decrypt datapath can reuse it.
module aes_shift_rows_perm
  import aes_pkg::*;
(
  input  logic       dir_i,
  input  aes_state_t state_i,
  output aes_state_t state_o
);

  assign state_o = dir_i ? inv_shift_rows(state_i) : shift_rows(state_i);

endmodule

// File: rtl/aes_shift_rows_collector.sv
// rtl/aes_shift_rows_collector.sv - gathers four ByteSub columns and emits the ShiftRows state
// Optional AES_SR_INV_EN adds an inv port selecting InvShiftRows per state.
module aes_shift_rows_collector
  import aes_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int NB     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
`ifdef AES_SR_INV_EN
  input  logic inv,
`endif
  aes_shift_rows_collector_if.slave bus
);

  if (BYTE_W != 8) begin : g_bad_byte_w
    $error("aes_shift_rows_collector: BYTE_W must be 8");
  end
  if (NB != 4) begin : g_bad_nb
    $error("aes_shift_rows_collector: NB must be 4");
  end

  logic [1:0] col_cnt_q, col_cnt_d;
  aes_col_t   buf_q [3];
  aes_col_t   buf_d [3];
  logic       out_valid_q, out_valid_d;
  aes_state_t out_state_q, out_state_d;
  logic       inv_q, inv_d;

  logic       col_xfer, out_xfer, load;
  aes_state_t perm_in, perm_out;

  // Last column may only enter when the output register is free or draining now.
  assign bus.col_ready = !clr && ((col_cnt_q != 2'd3) || !out_valid_q || bus.out_ready);
  assign col_xfer      = bus.col_valid && bus.col_ready;
  assign out_xfer      = out_valid_q && bus.out_ready;
  assign load          = col_xfer && (col_cnt_q == 2'd3);

  assign perm_in = {bus.col_data, buf_q[2], buf_q[1], buf_q[0]};

  aes_shift_rows_perm u_perm (
    .dir_i  (inv_q),
    .state_i(perm_in),
    .state_o(perm_out)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;

  always_comb begin
    col_cnt_d   = col_cnt_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    inv_d       = inv_q;
    if (clr) begin
      col_cnt_d   = 2'd0;
      out_valid_d = 1'b0;
      inv_d       = 1'b0;
    end else begin
      if (out_xfer) out_valid_d = 1'b0;
      if (col_xfer) begin
        col_cnt_d = col_cnt_q + 2'd1;
        case (col_cnt_q)
          2'd0: buf_d[0] = bus.col_data;
          2'd1: buf_d[1] = bus.col_data;
          2'd2: buf_d[2] = bus.col_data;
          default: ;
        endcase
`ifdef AES_SR_INV_EN
        if (col_cnt_q == 2'd0) inv_d = inv;
`endif
      end
      if (load) begin
        out_valid_d = 1'b1;
        out_state_d = perm_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      inv_q       <= 1'b0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      inv_q       <= inv_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_collector.sv
// tb/tb_aes_shift_rows_collector.sv - scoreboard bench for aes_shift_rows_collector
// Define AES_SR_INV_EN to also exercise the InvShiftRows path.
module tb_aes_shift_rows_collector;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
`ifdef AES_SR_INV_EN
  logic inv_s;
`endif

  aes_shift_rows_collector_if bus ();

  aes_shift_rows_collector dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
`ifdef AES_SR_INV_EN
    .inv  (inv_s),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  bit  stream_mode = 1'b0;
  int  last_out    = -1;

  localparam logic [127:0] APPB_IN  = {32'h3052411e, 32'he55db4b8, 32'hf198bfe0, 32'hae1127d4};
  localparam logic [127:0] APPB_OUT = {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[32*c+8*r +: 8] = s[32*src+8*r +: 8];
      end
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 128'd0, 128'd1);
      else chk("out_state", bus.out_state, sb.pop_front());
      if (stream_mode) begin
        if (last_out >= 0) chk("stream_gap", 128'(cyc - last_out), 128'd4);
        last_out = cyc;
      end
    end
  end

  task automatic send_col(input logic [31:0] data, output int waits);
    bus.col_valid = 1'b1;
    bus.col_data  = data;
    waits = 0;
    @(negedge clk);
    while (!bus.col_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 20) chk("col_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    bus.col_valid = 1'b0;
    bus.col_data  = $urandom;
  endtask

  task automatic send_state(input logic [127:0] s, input logic inv, output int waits);
    int w;
    sb.push_back(model(s, inv));
`ifdef AES_SR_INV_EN
    inv_s = inv;
`endif
    waits = 0;
    for (int c = 0; c < 4; c++) begin
      send_col(s[32*c +: 32], w);
      waits += w;
    end
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] s1, s2, exp1, exp2;
    int w;

    rst_n = 1'b0;
    clr   = 1'b0;
    bus.col_valid = 1'b0;
    bus.col_data  = '0;
    bus.out_ready = 1'b0;
`ifdef AES_SR_INV_EN
    inv_s = 1'b0;
`endif
    #12;
    chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset_out_state", bus.out_state, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_col_ready", 128'(bus.col_ready), 128'd1);
    @(posedge clk);
    #1;

    // FIPS-197 App. B round 1 with latency check
    bus.out_ready = 1'b1;
    sb.push_back(model(APPB_IN, 1'b0));
    for (int c = 0; c < 3; c++) send_col(APPB_IN[32*c +: 32], w);
    chk("appb_pre_valid", 128'(bus.out_valid), 128'd0);
    send_col(APPB_IN[96 +: 32], w);
    chk("appb_latency", 128'(bus.out_valid), 128'd1);
    chk("appb_state", bus.out_state, APPB_OUT);
    @(posedge clk);
    #1;
    chk("appb_drained", 128'(bus.out_valid), 128'd0);

    // Backpressure: second state waits on the fourth column
    bus.out_ready = 1'b0;
    s1 = rand_state();
    s2 = rand_state();
    exp1 = model(s1, 1'b0);
    exp2 = model(s2, 1'b0);
    send_state(s1, 1'b0, w);
    sb.push_back(exp2);
    for (int c = 0; c < 3; c++) send_col(s2[32*c +: 32], w);
    chk("bp_cols012_waits", 128'(w), 128'd0);
    bus.col_valid = 1'b1;
    bus.col_data  = s2[96 +: 32];
    repeat (2) begin
      @(negedge clk);
      chk("bp_col_ready_low", 128'(bus.col_ready), 128'd0);
      chk("bp_state_stable", bus.out_state, exp1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_col_ready_comb", 128'(bus.col_ready), 128'd1);
    @(posedge clk);
    #1;
    bus.col_valid = 1'b0;
    chk("bp_valid_held", 128'(bus.out_valid), 128'd1);
    chk("bp_state2", bus.out_state, exp2);
    @(posedge clk);
    #1;
    chk("bp_drained", 128'(bus.out_valid), 128'd0);

    // Streaming: three states back to back
    stream_mode = 1'b1;
    last_out    = -1;
    for (int k = 0; k < 3; k++) begin
      send_state(rand_state(), 1'b0, w);
      chk("stream_col_waits", 128'(w), 128'd0);
    end
    @(posedge clk);
    #1;
    stream_mode = 1'b0;

    // clr after two columns, then App. B again
    send_col($urandom, w);
    send_col($urandom, w);
    clr = 1'b1;
    #1;
    chk("clr_col_ready", 128'(bus.col_ready), 128'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send_state(APPB_IN, 1'b0, w);
    chk("clr_appb_state", bus.out_state, APPB_OUT);
    @(posedge clk);
    #1;

    // clr drops a pending output
    bus.out_ready = 1'b0;
    send_state(rand_state(), 1'b0, w);
    chk("clr_pending_valid", 128'(bus.out_valid), 128'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_drops_valid", 128'(bus.out_valid), 128'd0);
    void'(sb.pop_back());

    // Asynchronous reset mid-state with an output pending
    send_state(rand_state(), 1'b0, w);
    send_col($urandom, w);
    send_col($urandom, w);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_out_state", bus.out_state, 128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_state(rand_state(), 1'b0, w);
    @(posedge clk);
    #1;

`ifdef AES_SR_INV_EN
    send_state(APPB_OUT, 1'b1, w);
    chk("inv_appb_state", bus.out_state, APPB_IN);
    @(posedge clk);
    #1;
    inv_s = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
